// File: rtl/sar_adc_sampler_if.sv
// ADC handshake (start/den/dout) and downstream valid/ready stream of the SAR sampler.
// master = sampler side, slave = ADC model / downstream consumer side.
interface sar_adc_sampler_if #(
  parameter int unsigned ADC_WIDTH = 8
);
  logic                 adc_start;
  logic                 adc_den;
  logic [ADC_WIDTH-1:0] adc_dout;
  logic [ADC_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output adc_start,
    input  adc_den,
    input  adc_dout,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  adc_start,
    output adc_den,
    output adc_dout,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sar_adc_sampler.sv
// SAR ADC sampler: paces conversions (timer or trig), collects results into a one-entry holding register.
// Optional averaging of 2^AVG_LOG2 captures is enabled by defining SAR_AVG_EN.
module sar_adc_sampler #(
  parameter int unsigned ADC_WIDTH = 8,
  parameter int unsigned PERIOD    = 64,
  parameter int unsigned TIMEOUT   = 32,
  parameter int unsigned AVG_LOG2  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic trig,
  input  logic ovr_clr,
  output logic busy,
  output logic ovr,
  output logic tmo,
  sar_adc_sampler_if.master bus
);

  localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit CFG_OK = (PERIOD >= ADC_WIDTH + 4) && (TIMEOUT >= ADC_WIDTH + 2) && (AVG_LOG2 <= 4);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("sar_adc_sampler: illegal PERIOD/TIMEOUT/AVG_LOG2 combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [TO_W-1:0]      tcnt_q, tcnt_d;
  logic                 pending_q, pending_d;
  logic                 adc_start_q, adc_start_d;
  logic [ADC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic                 tmo_q, tmo_d;

  logic                 timer_term;
  logic                 req;
  logic                 cap;
  logic                 pop;
  logic                 push;
  logic [ADC_WIDTH-1:0] push_data;
  logic                 ovr_set;

`ifdef SAR_AVG_EN
  localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] avg_cnt_q, avg_cnt_d;
  logic [ACC_W-1:0] acc_sum;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    tcnt_d      = tcnt_q;
    pending_d   = pending_q;
    adc_start_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tmo_d       = 1'b0;
    cap         = 1'b0;
    ovr_set     = 1'b0;
    push        = 1'b0;
    push_data   = bus.adc_dout;
`ifdef SAR_AVG_EN
    acc_d       = acc_q;
    avg_cnt_d   = avg_cnt_q;
    acc_sum     = acc_q + ACC_W'(bus.adc_dout);
`endif

    // Period timer; held at zero while disabled.
    timer_term = en && (timer_q == TMR_W'(PERIOD - 1));
    if (!en || timer_term) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    // Coincident timer/trig requests merge into one; anything arriving while occupied is an overrun.
    req = timer_term || trig;
    if (req) begin
      if (pending_q || (state_q != S_IDLE)) begin
        ovr_set = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d     = S_START;
          pending_d   = 1'b0;
          tcnt_d      = '0;
          adc_start_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        tcnt_d  = tcnt_q + TO_W'(1);
      end
      S_WAIT: begin
        if (bus.adc_den) begin
          cap     = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SAR_AVG_EN
    // Only the completed average reaches the holding register.
    if (cap) begin
      if (avg_cnt_q == CNT_W'((2 ** AVG_LOG2) - 1)) begin
        push      = 1'b1;
        push_data = ADC_WIDTH'(acc_sum >> AVG_LOG2);
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + CNT_W'(1);
      end
    end
`else
    push = cap;
`endif

    // One-entry holding register; a simultaneous pop makes room for the new sample.
    pop = out_valid_q && bus.out_ready;
    if (pop) begin
      out_valid_d = 1'b0;
    end
    if (push) begin
      if (out_valid_q && !pop) begin
        ovr_set = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = push_data;
      end
    end

    busy_d = (state_d != S_IDLE);
    ovr_d  = ovr_clr ? 1'b0 : (ovr_q || ovr_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tcnt_q      <= '0;
      pending_q   <= 1'b0;
      adc_start_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      tmo_q       <= 1'b0;
`ifdef SAR_AVG_EN
      acc_q       <= '0;
      avg_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tcnt_q      <= tcnt_d;
      pending_q   <= pending_d;
      adc_start_q <= adc_start_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      tmo_q       <= tmo_d;
`ifdef SAR_AVG_EN
      acc_q       <= acc_d;
      avg_cnt_q   <= avg_cnt_d;
`endif
    end
  end

  assign bus.adc_start = adc_start_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign ovr           = ovr_q;
  assign tmo           = tmo_q;

endmodule
